// File: rtl/rw_pkg.sv
// rw_pkg: shared source-select encoding, stage layout and defaults for the writeback pipe.
package rw_pkg;

    localparam int RW_LINK_REG = 15;
    localparam int RW_PC_STEP  = 4;
    localparam int RW_DATA_W   = 32;
    localparam int RW_ADDR_W   = 4;

    // Encoded as {is_ld, is_call} so decode is a plain cast
    typedef enum logic [1:0] {
        SRC_ALU     = 2'b00,
        SRC_LINK    = 2'b01,
        SRC_LD      = 2'b10,
        SRC_ILLEGAL = 2'b11
    } rw_src_e;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic [RW_ADDR_W-1:0] addr;
        logic [RW_DATA_W-1:0] data;
    } rw_stage_t;

    function automatic rw_src_e rw_decode(input logic is_ld, input logic is_call);
        return rw_src_e'({is_ld, is_call});
    endfunction

endpackage

// File: rtl/rw_fwd_mux.sv
// rw_fwd_mux: youngest-first match of a query address against the in-flight stages.
module rw_fwd_mux #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic [DEPTH-1:0]             live,
    input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] data,
    input  logic [ADDR_W-1:0]            q_addr,
    output logic                         q_hit,
    output logic [DATA_W-1:0]            q_data
);

    // Scan oldest to youngest so the youngest match is written last
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (live[i] && addr[i] == q_addr) begin
                q_hit  = 1'b1;
                q_data = data[i];
            end
        end
    end

endmodule

// File: rtl/rw_writeback_pipe.sv
// rw_writeback_pipe: source select, aligned writeback pipeline with stall/flush, forwarding and retire count.
module rw_writeback_pipe
    import rw_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int DEST_LSB   = 22,
    parameter int LINK_REG   = RW_LINK_REG,
    parameter int PC_STEP    = RW_PC_STEP,
    parameter int PIPE_DEPTH = 1,
    parameter int ZERO_WIRED = 0,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic              is_call,
    input  logic              is_ld,
    input  logic              is_wb,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] ld_result,
    input  logic [31:0]       inst,
    input  logic [DATA_W-1:0] pc,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data,
    output logic              err_illegal,
    output logic [CNT_W-1:0]  retire_cnt
);

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    stage_t  s [PIPE_DEPTH];
    stage_t  in_e;
    rw_src_e src;
    logic    accept;
    logic    unused_inst;

    logic [PIPE_DEPTH-1:0]             live;
    logic [PIPE_DEPTH-1:0][ADDR_W-1:0] s_addr;
    logic [PIPE_DEPTH-1:0][DATA_W-1:0] s_data;

    assign unused_inst = ^inst;
    assign accept      = in_valid && !stall && !flush;

    always_comb begin
        src        = rw_decode(is_ld, is_call);
        in_e.valid = in_valid;
        in_e.addr  = src == SRC_LINK ? ADDR_W'(LINK_REG) : inst[DEST_LSB +: ADDR_W];
        in_e.data  = src == SRC_LINK ? pc + DATA_W'(PC_STEP) :
                     src == SRC_LD   ? ld_result :
                     src == SRC_ALU  ? alu_result : '0;
        in_e.we    = is_wb && src != SRC_ILLEGAL && !(ZERO_WIRED != 0 && in_e.addr == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DEPTH; i++) s[i] <= '0;
            err_illegal <= 1'b0;
            retire_cnt  <= '0;
        end else begin
            if (flush) begin
                for (int i = 0; i < PIPE_DEPTH; i++) s[i].valid <= 1'b0;
            end else if (!stall) begin
                s[0] <= in_e;
                for (int i = 1; i < PIPE_DEPTH; i++) s[i] <= s[i-1];
            end
            if (accept && src == SRC_ILLEGAL) err_illegal <= 1'b1;
            retire_cnt <= retire_cnt + CNT_W'(wb_en);
        end
    end

    // Gating with stall/flush makes the commit coincide with the edge the entry leaves
    assign wb_en   = s[PIPE_DEPTH-1].valid && s[PIPE_DEPTH-1].we && !stall && !flush;
    assign wb_addr = s[PIPE_DEPTH-1].addr;
    assign wb_data = s[PIPE_DEPTH-1].data;

    always_comb begin
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            live[i]   = s[i].valid && s[i].we;
            s_addr[i] = s[i].addr;
            s_data[i] = s[i].data;
        end
    end

    rw_fwd_mux #(
        .DEPTH (PIPE_DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_fwd (
        .live  (live),
        .addr  (s_addr),
        .data  (s_data),
        .q_addr(q_addr),
        .q_hit (q_hit),
        .q_data(q_data)
    );

endmodule

// File: doc/rw_writeback_pipe.md
# rw_writeback_pipe

Parametrised register-write (writeback) stage for the pipelined core, successor to the single-stage writeback block. It selects the result source (ALU result, load data, or call link address), extracts the destination register from the instruction word, and carries address, data and write enable together through a configurable number of aligned pipeline stages. It also supports stall and flush, forwards in-flight results to a query port, detects illegal source encodings, and counts retired writes. Its outputs drive the register file write port directly.

## Interface
Parameters:
- DATA_W, 32, datapath / register width
- ADDR_W, 4, register address width
- DEST_LSB, 22, LSB of the destination field in `inst`; the field is `inst[DEST_LSB+ADDR_W-1:DEST_LSB]`
- LINK_REG, 15, destination register for calls
- PC_STEP, 4, link offset added to `pc`
- PIPE_DEPTH, 1, number of stages, legal range 1..4
- ZERO_WIRED, 0, when 1, any write to register 0 is suppressed
- CNT_W, 16, retire counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input entry is valid this cycle
- stall  in  1  freeze all stages
- flush  in  1  invalidate all stages and the input
- is_call  in  1  link-write select
- is_ld  in  1  load-data select
- is_wb  in  1  entry writes the register file
- alu_result  in  DATA_W  ALU result
- ld_result  in  DATA_W  load data
- inst  in  32  instruction word
- pc  in  DATA_W  instruction PC
- q_addr  in  ADDR_W  forwarding query address
- wb_en  out  1  register file write enable
- wb_addr  out  ADDR_W  register file write address
- wb_data  out  DATA_W  register file write data
- q_hit  out  1  an in-flight entry matches `q_addr`
- q_data  out  DATA_W  data from the youngest matching entry
- err_illegal  out  1  sticky flag: `is_ld` and `is_call` were both seen on an accepted entry
- retire_cnt  out  CNT_W  number of committed writes

## Operation
- Source select on each accepted entry:
  - `is_call=1`, `is_ld=0`: data = pc+PC_STEP, address = LINK_REG.
  - `is_ld=1`, `is_call=0`: data = ld_result, address = destination field.
  - Both 0: data = alu_result, address = destination field.
  - Both 1: illegal. Data = 0, we = 0, and err_illegal is set.
- Link arithmetic is modulo 2^DATA_W; wrap-around is silent.
- Per-entry we = is_wb & legal & ~(ZERO_WIRED & addr==0).
- Stage array s[0..PIPE_DEPTH-1]; each stage holds {valid, we, addr, data}.
- Clock-edge update, in priority order:
  - flush=1: all valid bits cleared; the input is dropped. Flush has priority over stall.
  - Else stall=1: all stages hold; the input is dropped (upstream holds it).
  - Else shift: s[0] ← input (valid = in_valid), s[i] ← s[i-1].
- Outputs:
  - wb_addr and wb_data come from s[D-1] (D = PIPE_DEPTH).
  - wb_en = s[D-1].valid & s[D-1].we & ~stall & ~flush. It is combinational in stall and flush, so each entry commits exactly once, on the edge where it leaves the last stage.
- retire_cnt increments on every edge where wb_en=1 and wraps at 2^CNT_W.
- err_illegal is cleared only by reset.
- Forwarding query:
  - q_hit=1 if any stage has valid & we & addr==q_addr.
  - q_data is taken from the lowest-index (youngest) matching stage; it is 0 when there is no hit.
  - The query is combinational and ignores stall and flush.

## Timing
- Reset (async assert, sync deassert upstream):
  - All valid bits 0, wb_en 0, wb_addr 0, wb_data 0.
  - q_hit 0, q_data 0, err_illegal 0, retire_cnt 0.
- Reset mid-operation discards every in-flight entry without committing it.
- Latency: an entry accepted at edge N is presented on wb_* during the cycle after edge N+D-1 and commits at edge N+D, absent stalls. Each stall cycle adds one cycle.
- Throughput is one entry per cycle. Back-to-back entries to the same address commit in order.
- err_illegal and retire_cnt update at the clock edge, one cycle after the triggering event.

## Structure
- Shared package `rw_pkg`:
  - Enum for the source select: SRC_ALU, SRC_LD, SRC_LINK, SRC_ILLEGAL.
  - Packed stage struct {valid, we, addr, data}.
  - Default constants for LINK_REG and PC_STEP.
- Sub-module `rw_fwd_mux`: PIPE_DEPTH-way youngest-first priority match producing q_hit and q_data.
- Top level: source decode, stage array, commit logic, counter.

## Test plan
- D=1: ALU entry with alu_result=0xA5A5A5A5 and inst[25:22]=3 → the next cycle shows wb_en=1, wb_addr=3, wb_data=0xA5A5A5A5; retire_cnt becomes 1.
- D=3: call with pc=0xFFFFFFFE, PC_STEP=4 → three cycles later wb_addr=15, wb_data=0x00000002.
- D=2: stall held for 3 cycles while a load entry (data 0x5A5A5A5A) is in s[1] → wb_en stays 0 during the stall; a single wb_en pulse follows release; retire_cnt advances by exactly 1.
- D=4: entries to r5 with 0x11 then 0x22, q_addr=5 → q_hit=1 and q_data=0x22 while both are in flight; flush clears q_hit, and neither entry commits.
- is_ld=is_call=1 with is_wb=1 → no commit, err_illegal=1 until rst_n low. With ZERO_WIRED=1, an entry to r0 → wb_en never asserts.
- rst_n asserted with entries in every stage → all outputs zero immediately; the first entry after release commits with correct latency.
